// File: rtl/uptime_bcd_ud.sv
// N-digit packed-BCD up/down counter with clear, load, wrap/saturate and limit pulses.
// Optional macro UPTIME_BCD_LOAD_CHECK_EN: rejects non-BCD loads and reports them on load_err.

module uptime_bcd_digit (
  input  logic [3:0] d,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] nxt
);
  always_comb begin
    nxt = d;
    if (inc)      nxt = (d == 4'd9) ? 4'd0 : d + 4'd1;
    else if (dec) nxt = (d == 4'd0) ? 4'd9 : d - 4'd1;
  end
endmodule

module uptime_bcd_ud #(
  parameter int P_DIGITS = 3,
  parameter int P_WRAP   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_en,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*P_DIGITS-1:0] load_val,
`ifdef UPTIME_BCD_LOAD_CHECK_EN
  output logic                  load_err,
`endif
  output logic [4*P_DIGITS-1:0] digits,
  output logic                  ovf,
  output logic                  unf,
  output logic                  at_max,
  output logic                  at_zero
);
  logic [P_DIGITS-1:0][3:0] cnt_q, cnt_d, cnt_step, ld_v;
  logic [P_DIGITS:0]        all9, all0;
  logic                     ovf_d, unf_d;

  assign ld_v    = load_val;
  assign all9[0] = 1'b1;
  assign all0[0] = 1'b1;

  // Carry/borrow enables ripple combinationally so a full rollover lands in one edge.
  for (genvar g = 0; g < P_DIGITS; g++) begin : g_dig
    assign all9[g+1] = all9[g] & (cnt_q[g] == 4'd9);
    assign all0[g+1] = all0[g] & (cnt_q[g] == 4'd0);
    uptime_bcd_digit u_dig (
      .d   (cnt_q[g]),
      .inc (tick_en & up_dn & all9[g]),
      .dec (tick_en & ~up_dn & all0[g]),
      .nxt (cnt_step[g])
    );
  end

  assign at_max  = all9[P_DIGITS];
  assign at_zero = all0[P_DIGITS];
  assign digits  = cnt_q;

`ifdef UPTIME_BCD_LOAD_CHECK_EN
  logic [P_DIGITS-1:0] nib_bad;
  logic                err_d;
  for (genvar g = 0; g < P_DIGITS; g++) begin : g_chk
    assign nib_bad[g] = (ld_v[g] > 4'd9);
  end
`endif

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    unf_d = 1'b0;
`ifdef UPTIME_BCD_LOAD_CHECK_EN
    err_d = 1'b0;
`endif
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
`ifdef UPTIME_BCD_LOAD_CHECK_EN
      if (|nib_bad) err_d = 1'b1;
      else          cnt_d = ld_v;
`else
      cnt_d = ld_v;
`endif
    end else if (tick_en) begin
      // At a limit the digit chain already produces the wrapped value; saturate just holds.
      if (up_dn && at_max) begin
        ovf_d = 1'b1;
        if (P_WRAP != 0) cnt_d = cnt_step;
      end else if (!up_dn && at_zero) begin
        unf_d = 1'b1;
        if (P_WRAP != 0) cnt_d = cnt_step;
      end else begin
        cnt_d = cnt_step;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf   <= ovf_d;
      unf   <= unf_d;
    end
  end

`ifdef UPTIME_BCD_LOAD_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) load_err <= 1'b0;
    else      load_err <= err_d;
  end
`endif

endmodule

// File: tb/tb_uptime_bcd_ud.sv
// Directed table-driven bench for uptime_bcd_ud: a wrapping and a saturating instance share stimulus.
module tb_uptime_bcd_ud;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_en = 1'b0, up_dn = 1'b0, clear = 1'b0, load = 1'b0;
  logic [11:0] load_val = '0;
  logic [11:0] dig_w, dig_s;
  logic        ovf_w, unf_w, amax_w, azero_w;
  logic        ovf_s, unf_s, amax_s, azero_s;
`ifdef UPTIME_BCD_LOAD_CHECK_EN
  logic        lerr_w, lerr_s;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uptime_bcd_ud #(.P_DIGITS(3), .P_WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .tick_en(tick_en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val),
`ifdef UPTIME_BCD_LOAD_CHECK_EN
    .load_err(lerr_w),
`endif
    .digits(dig_w), .ovf(ovf_w), .unf(unf_w), .at_max(amax_w), .at_zero(azero_w));

  uptime_bcd_ud #(.P_DIGITS(3), .P_WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .tick_en(tick_en), .up_dn(up_dn), .clear(clear),
    .load(load), .load_val(load_val),
`ifdef UPTIME_BCD_LOAD_CHECK_EN
    .load_err(lerr_s),
`endif
    .digits(dig_s), .ovf(ovf_s), .unf(unf_s), .at_max(amax_s), .at_zero(azero_s));

  typedef struct {
    logic        clr, ld;
    logic [11:0] lv;
    logic        tk, up;
    logic [11:0] dw;
    logic        ow, uw;
    logic [11:0] ds;
    logic        os, us;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic clr, logic ld, logic [11:0] lv, logic tk, logic up,
                              logic [11:0] dw, logic ow, logic uw,
                              logic [11:0] ds, logic os, logic us);
    vec_t v;
    v.clr = clr; v.ld = ld; v.lv = lv; v.tk = tk; v.up = up;
    v.dw = dw; v.ow = ow; v.uw = uw; v.ds = ds; v.os = os; v.us = us;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_both(string tag, logic [11:0] dw, logic ow, logic uw,
                            logic [11:0] ds, logic os, logic us);
    check({tag, " wrap digits"},  32'(dig_w),   32'(dw));
    check({tag, " wrap ovf"},     32'(ovf_w),   32'(ow));
    check({tag, " wrap unf"},     32'(unf_w),   32'(uw));
    check({tag, " wrap at_max"},  32'(amax_w),  32'(dw == 12'h999));
    check({tag, " wrap at_zero"}, 32'(azero_w), 32'(dw == 12'h000));
    check({tag, " sat digits"},   32'(dig_s),   32'(ds));
    check({tag, " sat ovf"},      32'(ovf_s),   32'(os));
    check({tag, " sat unf"},      32'(unf_s),   32'(us));
    check({tag, " sat at_max"},   32'(amax_s),  32'(ds == 12'h999));
    check({tag, " sat at_zero"},  32'(azero_s), 32'(ds == 12'h000));
  endtask

  task automatic drive(logic clr, logic ld, logic [11:0] lv, logic tk, logic up);
    @(negedge clk);
    clear = clr; load = ld; load_val = lv; tick_en = tk; up_dn = up;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            clr ld  lv      tk up   wrap: dig    ovf unf  sat: dig   ovf unf
    vecs.push_back(mk(0, 1, 12'h998, 0, 0, 12'h998, 0, 0, 12'h998, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h999, 0, 0, 12'h999, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h000, 1, 0, 12'h999, 1, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h000, 0, 0, 12'h999, 0, 0));
    vecs.push_back(mk(0, 1, 12'h999, 0, 0, 12'h999, 0, 0, 12'h999, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h000, 1, 0, 12'h999, 1, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h001, 0, 0, 12'h999, 1, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h002, 0, 0, 12'h999, 1, 0));
    vecs.push_back(mk(0, 0, 12'h000, 0, 1, 12'h002, 0, 0, 12'h999, 0, 0));
    vecs.push_back(mk(0, 1, 12'h100, 0, 0, 12'h100, 0, 0, 12'h100, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h099, 0, 0, 12'h099, 0, 0));
    vecs.push_back(mk(0, 1, 12'h000, 0, 0, 12'h000, 0, 0, 12'h000, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h999, 0, 1, 12'h000, 0, 1));
    vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h998, 0, 0, 12'h000, 0, 1));
    vecs.push_back(mk(0, 0, 12'h000, 0, 0, 12'h998, 0, 0, 12'h000, 0, 0));
    vecs.push_back(mk(1, 1, 12'h555, 1, 1, 12'h000, 0, 0, 12'h000, 0, 0));
    vecs.push_back(mk(0, 1, 12'h555, 1, 1, 12'h555, 0, 0, 12'h555, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h556, 0, 0, 12'h556, 0, 0));
    vecs.push_back(mk(0, 1, 12'h199, 0, 0, 12'h199, 0, 0, 12'h199, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h200, 0, 0, 12'h200, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h199, 0, 0, 12'h199, 0, 0));
    vecs.push_back(mk(0, 1, 12'h090, 1, 0, 12'h090, 0, 0, 12'h090, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h091, 0, 0, 12'h091, 0, 0));
    vecs.push_back(mk(0, 1, 12'h009, 0, 0, 12'h009, 0, 0, 12'h009, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 1, 12'h010, 0, 0, 12'h010, 0, 0));
    vecs.push_back(mk(0, 0, 12'h000, 1, 0, 12'h009, 0, 0, 12'h009, 0, 0));
    vecs.push_back(mk(1, 0, 12'h000, 1, 0, 12'h000, 0, 0, 12'h000, 0, 0));

    // Reset state, held across a couple of edges.
    repeat (2) @(posedge clk);
    #1;
    check_both("reset", 12'h000, 0, 0, 12'h000, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    // 12 consecutive up-ticks from zero.
    tick_en = 1'b1; up_dn = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    tick_en = 1'b0;
    check_both("12 ticks", 12'h012, 0, 0, 12'h012, 0, 0);

    // Asynchronous reset asserted mid-tick, between edges.
    tick_en = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_both("async rst", 12'h000, 0, 0, 12'h000, 0, 0);
    tick_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].clr, vecs[i].ld, vecs[i].lv, vecs[i].tk, vecs[i].up);
      check_both($sformatf("vec%0d", i), vecs[i].dw, vecs[i].ow, vecs[i].uw,
                 vecs[i].ds, vecs[i].os, vecs[i].us);
    end

`ifdef UPTIME_BCD_LOAD_CHECK_EN
    drive(0, 1, 12'h123, 0, 0);
    check("lchk valid digits", 32'(dig_w), 32'h123);
    check("lchk valid err",    32'(lerr_w), 32'd0);
    drive(0, 1, 12'h1A3, 0, 0);
    check("lchk bad digits",   32'(dig_w), 32'h123);
    check("lchk bad err",      32'(lerr_w), 32'd1);
    check("lchk bad err sat",  32'(lerr_s), 32'd1);
    drive(0, 0, 12'h000, 0, 0);
    check("lchk err pulse",    32'(lerr_w), 32'd0);
    drive(0, 1, 12'h456, 0, 0);
    check("lchk reload digits", 32'(dig_w), 32'h456);
    check("lchk reload err",    32'(lerr_w), 32'd0);
    drive(1, 1, 12'hF00, 0, 0);
    check("lchk clear digits",  32'(dig_w), 32'h000);
    check("lchk clear err",     32'(lerr_w), 32'd0);
`endif

    @(negedge clk);
    clear = 0; load = 0; tick_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uptime_bcd_ud.md
Name: uptime_bcd_ud

Overview:
- Parametrised successor of the BCD uptime counter.
- N-digit packed-BCD counter that counts up or down on a qualified tick.
- Supports synchronous clear and parallel load, and wrap-around or saturation at the range limits.
- Registered overflow/underflow pulses and limit flags let it drive cascaded display/UART timers, countdown timers and uptime readouts.

Parameters:
- P_DIGITS, 3, number of BCD digits (1..8); value range 0..10^P_DIGITS-1.
- P_WRAP, 1, 1 = wrap at limits; 0 = saturate at limits.

Ports:
- clk  in  1  clock, active positive edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- tick_en  in  1  count qualifier, one clk-cycle pulse per count
- up_dn  in  1  1 = count up, 0 = count down; sampled with tick_en
- clear  in  1  synchronous clear to zero
- load  in  1  synchronous parallel load
- load_val  in  4*P_DIGITS  packed BCD load value, digit 0 in [3:0]
- digits  out  4*P_DIGITS  packed BCD count, registered
- ovf  out  1  one-cycle pulse: up-count attempted at max
- unf  out  1  one-cycle pulse: down-count attempted at zero
- at_max  out  1  combinational: digits == all 9s
- at_zero  out  1  combinational: digits == 0

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous-to-clk release):
  - digits=0, ovf=0, unf=0.
  - at_zero=1, at_max=0.
- Priority per clk edge: clear > load > tick_en > hold.
- clear=1: digits<=0 next edge; ovf/unf<=0; tick and load ignored.
- load=1 (clear=0): digits<=load_val next edge; ovf/unf<=0; tick ignored.
- tick_en=1, up_dn=1:
  - Digit i increments when all lower digits are 9.
  - A digit at 9 that increments becomes 0 and carries to the next digit.
  - Example: 0x199 -> 0x200.
- tick_en=1, up_dn=0:
  - Digit i decrements when all lower digits are 0.
  - A digit at 0 that decrements becomes 9 and borrows from the next digit.
  - Example: 0x200 -> 0x199.
- Up at max (all 9s):
  - P_WRAP=1: digits<=0, ovf<=1.
  - P_WRAP=0: digits hold, ovf<=1 on every attempted tick.
- Down at zero:
  - P_WRAP=1: digits<=all 9s, unf<=1.
  - P_WRAP=0: digits hold, unf<=1 on every attempted tick.
- Latency:
  - digits, ovf and unf update on the same edge, one cycle after the qualifying inputs are sampled.
  - ovf/unf are high for exactly one cycle per event; they are cleared on any edge without a limit event.
  - Back-to-back ticks at a limit give back-to-back pulses.
- tick_en=0, no clear/load: all registers hold; ovf/unf<=0.
- Carry/borrow chains are combinational from the registered digits. No multi-cycle ripple: any N-digit rollover completes in one edge.
- Arithmetic is per-digit BCD only; a digit never takes the values A..F through counting.
- Reset asserted mid-operation overrides all inputs immediately (asynchronous), including within a cycle where clear or load is active.
- up_dn changes are only meaningful when tick_en=1; no direction state is stored.

Optional Feature:
- Macro: UPTIME_BCD_LOAD_CHECK_EN.
- Defined:
  - load_val is checked per nibble.
  - If any nibble > 9, the load is rejected: digits hold, and extra output load_err pulses 1 for one cycle on that edge.
  - A valid load gives load_err=0.
  - load_err reset value is 0.
  - clear still takes priority; no check is made when clear=1.
- Not defined:
  - No load_err port and no check; load_val is loaded unchanged.
  - Non-BCD load values are outside the supported input range; the bench shall not drive them.

Test Plan:
All scenarios use P_DIGITS=3.
- Reset: rst=0 at any time, including mid-tick -> digits=0x000, ovf=unf=0, at_zero=1 asynchronously; release, 12 up-ticks -> digits=0x012.
- Up carry/wrap, P_WRAP=1: load 0x998, 2 up-ticks -> 0x999 (at_max=1), then 0x000 with ovf=1 for exactly one cycle; next idle cycle ovf=0.
- Down borrow/wrap, P_WRAP=1: load 0x100, down-tick -> 0x099; load 0x000, down-tick -> 0x999 with unf=1 for one cycle.
- Saturate, P_WRAP=0: load 0x999, 3 consecutive up-ticks -> digits stay 0x999, ovf high 3 consecutive cycles; at 0x000, 2 down-ticks -> hold, unf pulses twice.
- Priority: clear=1, load=1 (0x555), tick_en=1 together -> 0x000; load=1 (0x555) with tick_en=1 up -> 0x555, not 0x556.
- With UPTIME_BCD_LOAD_CHECK_EN: from 0x123, load 0x1A3 -> digits stay 0x123, load_err=1 for one cycle; load 0x456 -> 0x456, load_err=0.
